// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory request/done handshake between the fetch stage (master) and memory (slave).
interface fetch_ifid_stage_if;
  logic        rd;
  logic [15:0] addr;
  logic [15:0] data;
  logic        done;

  modport master (
    output rd,
    output addr,
    input  data,
    input  done
  );

  modport slave (
    input  rd,
    input  addr,
    output data,
    output done
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Fetch stage and IF/ID latch: owns the PC, runs the imem req/done handshake, honours hazard
// freezes, EX-resolved redirects and stops fetching once a HALT has been latched.
module fetch_ifid_stage #(
  parameter logic [15:0] ResetPc  = 16'h0000,
  parameter logic [15:0] NopInstr = 16'h0800,
  parameter logic [15:0] PcInc    = 16'd2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pc_write_en_i,
  input  logic                      ifid_write_en_i,
  input  logic                      flush_i,
  input  logic [15:0]               branch_target_i,
  fetch_ifid_stage_if.master        imem_io,
  output logic [15:0]               ifid_instr_o,
  output logic [15:0]               ifid_pc_inc_o,
  output logic                      ifid_valid_o,
  output logic                      fetch_stall_o,
  output logic                      halted_o
);

  typedef enum logic [1:0] {StFetch, StDrain, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_inc_q, pc_inc_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_next;
  logic        is_halt;

  assign pc_next = pc_q + PcInc;
  assign is_halt = (imem_io.data[15:11] == 5'b00000);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    pc_inc_d = pc_inc_q;
    valid_d  = valid_q;

    if (flush_i) begin
      pc_d     = branch_target_i;
      instr_d  = NopInstr;
      pc_inc_d = 16'h0000;
      valid_d  = 1'b0;
      unique case (state_q)
        StFetch: begin
          if (imem_io.done) begin
            addr_d  = branch_target_i;
            state_d = StFetch;
          end else begin
            // Read already in flight: its address must not move until done.
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (imem_io.done) begin
            addr_d  = branch_target_i;
            state_d = StFetch;
          end
        end
        StHalted: begin
          addr_d  = branch_target_i;
          state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_io.done) begin
            if (pc_write_en_i) begin
              pc_d   = pc_next;
              addr_d = pc_next;
            end
            if (ifid_write_en_i) begin
              instr_d  = imem_io.data;
              pc_inc_d = pc_next;
              valid_d  = 1'b1;
              if (is_halt) begin
                state_d = StHalted;
              end
            end
          end else if (ifid_write_en_i) begin
            instr_d = NopInstr;
            valid_d = 1'b0;
          end
        end
        StDrain: begin
          if (ifid_write_en_i) begin
            instr_d = NopInstr;
            valid_d = 1'b0;
          end
          // Stale data is dropped; reissue at the redirected PC.
          if (imem_io.done) begin
            addr_d  = pc_q;
            state_d = StFetch;
          end
        end
        StHalted: begin
          if (ifid_write_en_i) begin
            instr_d = NopInstr;
            valid_d = 1'b0;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= ResetPc;
      addr_q   <= ResetPc;
      instr_q  <= NopInstr;
      pc_inc_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      pc_inc_q <= pc_inc_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_io.rd     = !rst && (state_q != StHalted);
  assign imem_io.addr   = addr_q;
  assign ifid_instr_o   = instr_q;
  assign ifid_pc_inc_o  = pc_inc_q;
  assign ifid_valid_o   = valid_q;
  assign halted_o       = (state_q == StHalted);
  assign fetch_stall_o  = !rst && ((state_q == StDrain) || ((state_q == StFetch) && !imem_io.done));

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed vector table, then randomized stimulus vs a reference model.
module tb_fetch_ifid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcwe;
  logic        ifidwe;
  logic        flush;
  logic [15:0] bt;
  logic        done;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_inc;
  logic        ifid_valid;
  logic        fetch_stall;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ifid_stage_if imem_bus ();

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a[7:0] == 8'h10) return 16'h0000;
    if (a == 16'h0000) return 16'h4001;
    return 16'h4000 | {4'h0, a[11:0]};
  endfunction

  assign imem_bus.done = done;
  assign imem_bus.data = done ? mem_word(imem_bus.addr) : 16'hDEAD;

  fetch_ifid_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc_write_en_i   (pcwe),
    .ifid_write_en_i (ifidwe),
    .flush_i         (flush),
    .branch_target_i (bt),
    .imem_io         (imem_bus),
    .ifid_instr_o    (ifid_instr),
    .ifid_pc_inc_o   (ifid_pc_inc),
    .ifid_valid_o    (ifid_valid),
    .fetch_stall_o   (fetch_stall),
    .halted_o        (halted)
  );

  // Reference model: a PC, an outstanding-read address, a halted flag and a
  // "discard the read in flight" flag, plus the expected IF/ID contents.
  logic [15:0] m_pc, m_addr, m_instr, m_pcinc;
  logic        m_valid, m_halted, m_discard;

  task automatic model_step(input logic r, pw, iw, fl, input logic [15:0] tgt, input logic dn);
    logic [15:0] word, nxt;
    logic        busy;
    word = dn ? mem_word(m_addr) : 16'hDEAD;
    if (r) begin
      m_pc = 16'h0000; m_addr = 16'h0000; m_instr = 16'h0800; m_pcinc = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_discard = 1'b0;
    end else if (fl) begin
      busy      = m_discard || !m_halted;
      m_discard = busy && !dn;
      if (!m_discard) m_addr = tgt;
      m_pc = tgt; m_halted = 1'b0;
      m_instr = 16'h0800; m_valid = 1'b0; m_pcinc = 16'h0000;
    end else if (m_halted) begin
      if (iw) begin m_instr = 16'h0800; m_valid = 1'b0; end
    end else if (m_discard) begin
      if (iw) begin m_instr = 16'h0800; m_valid = 1'b0; end
      if (dn) begin m_discard = 1'b0; m_addr = m_pc; end
    end else if (dn) begin
      nxt = m_pc + 16'd2;
      if (iw) begin
        m_instr = word; m_pcinc = nxt; m_valid = 1'b1;
        m_halted = (word[15:11] == 5'd0);
      end
      if (pw) begin m_pc = nxt; m_addr = nxt; end
    end else if (iw) begin
      m_instr = 16'h0800; m_valid = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic act_rd, act_stall, exp_rd, exp_stall;

  // Drive one cycle: sample combinational outputs at negedge, advance model, wait past posedge.
  task automatic cycle(input logic r, pw, iw, fl, input logic [15:0] tgt, input logic dn);
    rst = r; pcwe = pw; ifidwe = iw; flush = fl; bt = tgt; done = dn;
    @(negedge clk);
    act_rd    = imem_bus.rd;
    act_stall = fetch_stall;
    exp_rd    = !r && !m_halted;
    exp_stall = !r && (m_discard || (!m_halted && !dn));
    model_step(r, pw, iw, fl, tgt, dn);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r, pw, iw, fl;
    logic [15:0] tgt;
    logic        dn;
    logic        e_rd, e_stall;
    logic [15:0] e_addr, e_instr, e_pcinc;
    logic        e_valid, e_halted;
  } vec_t;

  vec_t vecs[25];

  initial begin
    vecs[0]  = '{1, 1, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0800, 16'h0000, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0002, 16'h4001, 16'h0002, 1, 0};
    vecs[2]  = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0};
    vecs[3]  = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0};
    vecs[6]  = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0008, 16'h4006, 16'h0008, 1, 0};
    vecs[7]  = '{0, 1, 1, 0, 16'h0000, 0, 1, 1, 16'h0008, 16'h0800, 16'h0008, 0, 0};
    vecs[8]  = '{0, 1, 1, 0, 16'h0000, 0, 1, 1, 16'h0008, 16'h0800, 16'h0008, 0, 0};
    vecs[9]  = '{0, 1, 1, 0, 16'h0000, 0, 1, 1, 16'h0008, 16'h0800, 16'h0008, 0, 0};
    vecs[10] = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h000A, 16'h4008, 16'h000A, 1, 0};
    vecs[11] = '{0, 1, 1, 1, 16'h0040, 0, 1, 1, 16'h000A, 16'h0800, 16'h0000, 0, 0};
    vecs[12] = '{0, 1, 1, 0, 16'h0000, 0, 1, 1, 16'h000A, 16'h0800, 16'h0000, 0, 0};
    vecs[13] = '{0, 1, 1, 0, 16'h0000, 1, 1, 1, 16'h0040, 16'h0800, 16'h0000, 0, 0};
    vecs[14] = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0042, 16'h4040, 16'h0042, 1, 0};
    vecs[15] = '{0, 1, 1, 1, 16'h0010, 1, 1, 0, 16'h0010, 16'h0800, 16'h0000, 0, 0};
    vecs[16] = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0012, 16'h0000, 16'h0012, 1, 1};
    vecs[17] = '{0, 1, 1, 0, 16'h0000, 1, 0, 0, 16'h0012, 16'h0800, 16'h0012, 0, 1};
    vecs[18] = '{0, 1, 1, 1, 16'h0020, 1, 0, 0, 16'h0020, 16'h0800, 16'h0000, 0, 0};
    vecs[19] = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0022, 16'h4020, 16'h0022, 1, 0};
    vecs[20] = '{0, 1, 1, 1, 16'h0030, 0, 1, 1, 16'h0022, 16'h0800, 16'h0000, 0, 0};
    vecs[21] = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0800, 16'h0000, 0, 0};
    vecs[22] = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0002, 16'h4001, 16'h0002, 1, 0};
    vecs[23] = '{0, 1, 1, 1, 16'hFFFE, 1, 1, 0, 16'hFFFE, 16'h0800, 16'h0000, 0, 0};
    vecs[24] = '{0, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h4FFE, 16'h0000, 1, 0};

    rst = 1'b1; pcwe = 1'b1; ifidwe = 1'b1; flush = 1'b0; bt = 16'h0000; done = 1'b1;
    model_step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      cycle(vecs[i].r, vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].tgt, vecs[i].dn);
      check($sformatf("v%0d imemRd", i), {15'd0, act_rd}, {15'd0, vecs[i].e_rd});
      check($sformatf("v%0d fetchStall", i), {15'd0, act_stall}, {15'd0, vecs[i].e_stall});
      check($sformatf("v%0d imemAddr", i), imem_bus.addr, vecs[i].e_addr);
      check($sformatf("v%0d ifidInstr", i), ifid_instr, vecs[i].e_instr);
      check($sformatf("v%0d ifidPCinc", i), ifid_pc_inc, vecs[i].e_pcinc);
      check($sformatf("v%0d ifidValid", i), {15'd0, ifid_valid}, {15'd0, vecs[i].e_valid});
      check($sformatf("v%0d halted", i), {15'd0, halted}, {15'd0, vecs[i].e_halted});
    end

    for (int i = 0; i < 600; i++) begin
      logic        r, pw, iw, fl, dn;
      logic [15:0] tgt;
      r   = ($urandom_range(0, 39) == 0);
      pw  = ($urandom_range(0, 4) != 0);
      iw  = ($urandom_range(0, 4) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      dn  = ($urandom_range(0, 9) < 7);
      tgt = 16'($urandom) & 16'h00FE;
      if ($urandom_range(0, 5) == 0) tgt = 16'h0010;
      cycle(r, pw, iw, fl, tgt, dn);
      check($sformatf("r%0d imemRd", i), {15'd0, act_rd}, {15'd0, exp_rd});
      check($sformatf("r%0d fetchStall", i), {15'd0, act_stall}, {15'd0, exp_stall});
      check($sformatf("r%0d imemAddr", i), imem_bus.addr, m_addr);
      check($sformatf("r%0d ifidInstr", i), ifid_instr, m_instr);
      check($sformatf("r%0d ifidPCinc", i), ifid_pc_inc, m_pcinc);
      check($sformatf("r%0d ifidValid", i), {15'd0, ifid_valid}, {15'd0, m_valid});
      check($sformatf("r%0d halted", i), {15'd0, halted}, {15'd0, m_halted});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
